mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory stage of the pipelined MIPS core. Sits directly downstream of the execute-to-memory pipeline register and consumes its M-stage outputs.
- Contains the word-addressed data memory and a load-latency FSM that stalls the pipeline while a load completes.
- Also contains the memory-to-writeback pipeline register that drives the W-stage signals.

Parameters:
WIDTH, 32, data/address width
ADDR_BITS, 8, log2 of data memory depth in words (256 words)
RD_LAT, 2, extra wait cycles per load (legal 0..7)

Ports:
MEMSTAGE_CLK  input  1  clock, rising edge
MEMSTAGE_RST  input  1  asynchronous active-low reset
MEMSTAGE_AluOutM  input  WIDTH  byte address (store/load) or ALU result
MEMSTAGE_WriteDataM  input  WIDTH  store data
MEMSTAGE_WriteRegM  input  5  destination register
MEMSTAGE_RegWriteM  input  1  register write enable
MEMSTAGE_MemWriteM  input  1  store request
MEMSTAGE_MemToRegM  input  1  load request
MEMSTAGE_Stall  output  1  hold F/D/E stages and E/M register this cycle
MEMSTAGE_ReadDataW  output  WIDTH  loaded word
MEMSTAGE_AluOutW  output  WIDTH  registered AluOutM
MEMSTAGE_WriteRegW  output  5  registered destination
MEMSTAGE_RegWriteW  output  1  registered write enable
MEMSTAGE_MemToRegW  output  1  registered writeback select

Behaviour:
- Clock is MEMSTAGE_CLK. Reset is MEMSTAGE_RST, asynchronous and active-low.
- Reset values:
  - All W outputs 0.
  - FSM in IDLE, wait counter 0.
  - MEMSTAGE_Stall forced 0 while reset is asserted.
  - Memory array is not reset.
- Addressing:
  - Word index = AluOutM[ADDR_BITS+1:2].
  - Bits [1:0] are ignored. Upper bits are ignored, so addresses wrap modulo depth.
- Operation decode:
  - Store = MemWriteM. Store takes priority if MemWriteM and MemToRegM are both 1.
  - Load = MemToRegM & ~MemWriteM.
  - Pass = neither store nor load.
- Store:
  - Array written at the rising edge of the cycle it is presented in IDLE.
  - Single cycle, Stall never asserted.
  - W register captures the instruction as pass-through with ReadDataW = 0.
- FSM states: IDLE, WAIT.
  - IDLE, load, RD_LAT>0:
    - Stall=1, go to WAIT, cnt <= RD_LAT-1.
    - W register inserts a bubble: RegWriteW=0, MemToRegW=0, other W fields hold.
  - WAIT, cnt!=0: Stall=1, cnt decrements, bubble as above.
  - WAIT, cnt==0:
    - Stall=0.
    - ReadDataW <= mem[index], remaining W fields <= M inputs.
    - Return to IDLE.
  - IDLE, load, RD_LAT==0: no stall, ReadDataW <= mem[index] in the same edge.
  - IDLE, pass or store: W fields <= M inputs the next edge.
- Latencies:
  - A load occupies RD_LAT+1 cycles.
  - Stall is combinational: high for exactly RD_LAT cycles starting with the load's first cycle.
- Environment requirement: M inputs stay stable while Stall=1. The E/M register is held by the hazard unit.
- Store followed by a load to the same word in the next instruction returns the new data, because the write completed at the earlier edge.
- Reset asserted mid-WAIT:
  - Returns immediately to IDLE and the load is abandoned.
  - After release, the FSM treats the current M inputs as a new instruction.

Optional Feature:
- Macro MEMSTAGE_PERF_EN.
- When defined:
  - Adds output MEMSTAGE_StallCnt (16 bits), reset 0.
  - Increments on every clock with Stall=1 and saturates at 16'hFFFF.
- When undefined: port and counter are absent, and behaviour is otherwise identical.

Test Plan:
- RD_LAT=2, reset released with idle inputs → all W outputs 0, Stall 0, FSM IDLE.
- Store AluOutM=0x10, WriteDataM=0xDEADBEEF, then load AluOutM=0x10 WriteRegM=5 RegWriteM=1 → Stall high 2 cycles, bubbles on RegWriteW, then ReadDataW=0xDEADBEEF, WriteRegW=5, RegWriteW=1, MemToRegW=1.
- Pass-through AluOutM=0x1234, RegWriteM=1, WriteRegM=9 → next edge AluOutW=0x1234, WriteRegW=9, RegWriteW=1, Stall 0.
- Store at 0x0 then 0x400 with ADDR_BITS=8 → both hit word 0; a later load returns the second value (wrap). Load at 0x13 returns word 4.
- Reset pulse during the first WAIT cycle of a load → Stall 0 and W outputs 0 immediately. After release, the load restarts with a full 2-cycle stall.
- With MEMSTAGE_PERF_EN, three back-to-back loads at RD_LAT=2 → MEMSTAGE_StallCnt=6. Preload 0xFFFF → stays 0xFFFF.

Source files
------------

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage : memory stage of the pipelined MIPS core.
//
// Holds the word-addressed data memory, a two-state load-latency FSM that
// stalls the upstream pipeline while a load is in flight, and the
// memory-to-writeback pipeline register that drives the W-stage signals.
//
// Parameters
//   WIDTH      data/address width
//   ADDR_BITS  log2 of the data memory depth in words
//   RD_LAT     extra wait cycles per load (0..7)
//
// Ports
//   MEMSTAGE_CLK         clock, rising edge
//   MEMSTAGE_RST         asynchronous active-low reset
//   MEMSTAGE_AluOutM     byte address for load/store, or ALU result
//   MEMSTAGE_WriteDataM  store data
//   MEMSTAGE_WriteRegM   destination register
//   MEMSTAGE_RegWriteM   register write enable
//   MEMSTAGE_MemWriteM   store request
//   MEMSTAGE_MemToRegM   load request
//   MEMSTAGE_Stall       hold F/D/E stages and the E/M register this cycle
//   MEMSTAGE_ReadDataW   loaded word
//   MEMSTAGE_AluOutW     registered AluOutM
//   MEMSTAGE_WriteRegW   registered destination
//   MEMSTAGE_RegWriteW   registered write enable
//   MEMSTAGE_MemToRegW   registered writeback select
//   MEMSTAGE_StallCnt    saturating count of stalled cycles
//                        (only when MEMSTAGE_PERF_EN is defined)
//
// Optional feature macro: MEMSTAGE_PERF_EN
// -----------------------------------------------------------------------------
module mem_stage #(
  parameter int WIDTH     = 32,
  parameter int ADDR_BITS = 8,
  parameter int RD_LAT    = 2
) (
  input  logic             MEMSTAGE_CLK,
  input  logic             MEMSTAGE_RST,
  input  logic [WIDTH-1:0] MEMSTAGE_AluOutM,
  input  logic [WIDTH-1:0] MEMSTAGE_WriteDataM,
  input  logic [4:0]       MEMSTAGE_WriteRegM,
  input  logic             MEMSTAGE_RegWriteM,
  input  logic             MEMSTAGE_MemWriteM,
  input  logic             MEMSTAGE_MemToRegM,
  output logic             MEMSTAGE_Stall,
  output logic [WIDTH-1:0] MEMSTAGE_ReadDataW,
  output logic [WIDTH-1:0] MEMSTAGE_AluOutW,
  output logic [4:0]       MEMSTAGE_WriteRegW,
  output logic             MEMSTAGE_RegWriteW,
  output logic             MEMSTAGE_MemToRegW
`ifdef MEMSTAGE_PERF_EN
  ,
  output logic [15:0]      MEMSTAGE_StallCnt
`endif
);

  localparam int         DEPTH    = 1 << ADDR_BITS;
  localparam logic [2:0] CNT_INIT = (RD_LAT > 0) ? 3'(RD_LAT - 1) : 3'd0;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t state, state_n;
  logic [2:0] cnt, cnt_n;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [ADDR_BITS-1:0] idx;
  logic [WIDTH-1:0]     rd_word;
  logic                 is_store;
  logic                 is_load;

  // Control decoded from the FSM for the W register and the array.
  logic stall;
  logic w_cap;    // capture M inputs into the W register
  logic w_load;   // captured ReadDataW comes from the array (else 0)
  logic w_bub;    // insert a bubble: clear RegWriteW/MemToRegW, hold the rest
  logic mem_we;

  // W register contents
  logic [WIDTH-1:0] read_data_p1;
  logic [WIDTH-1:0] alu_out_p1;
  logic [4:0]       write_reg_p1;
  logic             reg_write_p1;
  logic             mem_to_reg_p1;

  // Byte address bits [1:0] and anything above the array depth are dropped,
  // so addresses alias modulo the memory size.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{MEMSTAGE_AluOutM[1:0],
                              MEMSTAGE_AluOutM[WIDTH-1:ADDR_BITS+2]};

  assign idx      = MEMSTAGE_AluOutM[ADDR_BITS+1:2];
  assign rd_word  = mem[idx];
  assign is_store = MEMSTAGE_MemWriteM;
  assign is_load  = MEMSTAGE_MemToRegM & ~MEMSTAGE_MemWriteM;

  // ---------------------------------------------------------------------------
  // Load-latency FSM: next state and datapath controls
  // ---------------------------------------------------------------------------
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    stall   = 1'b0;
    w_cap   = 1'b0;
    w_load  = 1'b0;
    w_bub   = 1'b0;
    mem_we  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (is_store) begin
          mem_we = 1'b1;
          w_cap  = 1'b1;
        end else if (is_load) begin
          if (RD_LAT > 0) begin
            stall   = 1'b1;
            w_bub   = 1'b1;
            state_n = S_WAIT;
            cnt_n   = CNT_INIT;
          end else begin
            w_cap  = 1'b1;
            w_load = 1'b1;
          end
        end else begin
          w_cap = 1'b1;
        end
      end
      S_WAIT: begin
        if (cnt != 3'd0) begin
          stall = 1'b1;
          w_bub = 1'b1;
          cnt_n = cnt - 3'd1;
        end else begin
          // Final load cycle: the M inputs have been held stable, so the
          // array read and the W capture both use the current inputs.
          w_cap   = 1'b1;
          w_load  = 1'b1;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Stall must be low for the whole time reset is held, regardless of inputs.
  assign MEMSTAGE_Stall = stall & MEMSTAGE_RST;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge MEMSTAGE_CLK or negedge MEMSTAGE_RST) begin
    if (!MEMSTAGE_RST) begin
      state <= S_IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // ---------------------------------------------------------------------------
  // Data memory (not reset); a store completes at the edge ending its cycle,
  // so a load in the following instruction already sees the new word.
  // ---------------------------------------------------------------------------
  always_ff @(posedge MEMSTAGE_CLK) begin
    if (mem_we && MEMSTAGE_RST) begin
      mem[idx] <= MEMSTAGE_WriteDataM;
    end
  end

  // ---------------------------------------------------------------------------
  // M -> W pipeline register
  // ---------------------------------------------------------------------------
  always_ff @(posedge MEMSTAGE_CLK or negedge MEMSTAGE_RST) begin
    if (!MEMSTAGE_RST) begin
      read_data_p1  <= '0;
      alu_out_p1    <= '0;
      write_reg_p1  <= '0;
      reg_write_p1  <= 1'b0;
      mem_to_reg_p1 <= 1'b0;
    end else if (w_cap) begin
      read_data_p1  <= w_load ? rd_word : '0;
      alu_out_p1    <= MEMSTAGE_AluOutM;
      write_reg_p1  <= MEMSTAGE_WriteRegM;
      reg_write_p1  <= MEMSTAGE_RegWriteM;
      mem_to_reg_p1 <= MEMSTAGE_MemToRegM;
    end else if (w_bub) begin
      reg_write_p1  <= 1'b0;
      mem_to_reg_p1 <= 1'b0;
    end
  end

  assign MEMSTAGE_ReadDataW = read_data_p1;
  assign MEMSTAGE_AluOutW   = alu_out_p1;
  assign MEMSTAGE_WriteRegW = write_reg_p1;
  assign MEMSTAGE_RegWriteW = reg_write_p1;
  assign MEMSTAGE_MemToRegW = mem_to_reg_p1;

`ifdef MEMSTAGE_PERF_EN
  // ---------------------------------------------------------------------------
  // Saturating stall-cycle counter
  // ---------------------------------------------------------------------------
  logic [15:0] perf_cnt;

  always_ff @(posedge MEMSTAGE_CLK or negedge MEMSTAGE_RST) begin
    if (!MEMSTAGE_RST) begin
      perf_cnt <= 16'd0;
    end else if (stall && (perf_cnt != 16'hFFFF)) begin
      perf_cnt <= perf_cnt + 16'd1;
    end
  end

  assign MEMSTAGE_StallCnt = perf_cnt;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage : directed, table-driven bench for mem_stage (RD_LAT=2,
// ADDR_BITS=8). Each table row is one clock cycle: the M inputs presented in
// that cycle, the Stall level expected during it, and the W outputs expected
// after its closing edge. Reset corner cases are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] alu_m;
  logic [31:0] wdata_m;
  logic [4:0]  wreg_m;
  logic        rw_m;
  logic        mw_m;
  logic        m2r_m;
  logic        stall;
  logic [31:0] rdata_w;
  logic [31:0] alu_w;
  logic [4:0]  wreg_w;
  logic        rw_w;
  logic        m2r_w;
`ifdef MEMSTAGE_PERF_EN
  logic [15:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  mem_stage #(
    .WIDTH    (32),
    .ADDR_BITS(8),
    .RD_LAT   (2)
  ) dut (
    .MEMSTAGE_CLK        (clk),
    .MEMSTAGE_RST        (rst_n),
    .MEMSTAGE_AluOutM    (alu_m),
    .MEMSTAGE_WriteDataM (wdata_m),
    .MEMSTAGE_WriteRegM  (wreg_m),
    .MEMSTAGE_RegWriteM  (rw_m),
    .MEMSTAGE_MemWriteM  (mw_m),
    .MEMSTAGE_MemToRegM  (m2r_m),
    .MEMSTAGE_Stall      (stall),
    .MEMSTAGE_ReadDataW  (rdata_w),
    .MEMSTAGE_AluOutW    (alu_w),
    .MEMSTAGE_WriteRegW  (wreg_w),
    .MEMSTAGE_RegWriteW  (rw_w),
    .MEMSTAGE_MemToRegW  (m2r_w)
`ifdef MEMSTAGE_PERF_EN
    ,
    .MEMSTAGE_StallCnt   (stall_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wr,
                       input logic rw, input logic mw, input logic m2r);
    alu_m   = alu;
    wdata_m = wd;
    wreg_m  = wr;
    rw_m    = rw;
    mw_m    = mw;
    m2r_m   = m2r;
  endtask

  task automatic chk_w(input string tag, input logic [31:0] rd, input logic [31:0] al,
                       input logic [4:0] wr, input logic rw, input logic m2r);
    chk({tag, " ReadDataW"}, rdata_w, rd);
    chk({tag, " AluOutW"},   alu_w,   al);
    chk({tag, " WriteRegW"}, 32'(wreg_w), 32'(wr));
    chk({tag, " RegWriteW"}, 32'(rw_w),   32'(rw));
    chk({tag, " MemToRegW"}, 32'(m2r_w),  32'(m2r));
  endtask

  typedef struct {
    logic [31:0] alu;
    logic [31:0] wd;
    logic [4:0]  wreg;
    logic        rw;
    logic        mw;
    logic        m2r;
    logic        e_stall;
    logic [31:0] e_rd;
    logic [31:0] e_alu;
    logic [4:0]  e_wreg;
    logic        e_rw;
    logic        e_m2r;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  initial begin
    //          alu           wd            wr  rw mw m2r | stall rd           aluW          wrW rwW m2rW
    // store 0xDEADBEEF at 0x10, then load it back (2 stall cycles with bubbles)
    vecs[0]  = '{32'h10,   32'hDEADBEEF, 5'd0, 0, 1, 0,  0, 32'h0,        32'h10,   5'd0, 0, 0};
    vecs[1]  = '{32'h10,   32'h0,        5'd5, 1, 0, 1,  1, 32'h0,        32'h10,   5'd0, 0, 0};
    vecs[2]  = '{32'h10,   32'h0,        5'd5, 1, 0, 1,  1, 32'h0,        32'h10,   5'd0, 0, 0};
    vecs[3]  = '{32'h10,   32'h0,        5'd5, 1, 0, 1,  0, 32'hDEADBEEF, 32'h10,   5'd5, 1, 1};
    // pass-through ALU result
    vecs[4]  = '{32'h1234, 32'h0,        5'd9, 1, 0, 0,  0, 32'h0,        32'h1234, 5'd9, 1, 0};
    // stores at 0x0 and 0x400 alias word 0; store to 0x10 (word 4)
    vecs[5]  = '{32'h0,    32'h11111111, 5'd0, 0, 1, 0,  0, 32'h0,        32'h0,    5'd0, 0, 0};
    vecs[6]  = '{32'h400,  32'h22222222, 5'd0, 0, 1, 0,  0, 32'h0,        32'h400,  5'd0, 0, 0};
    vecs[7]  = '{32'h10,   32'h44444444, 5'd0, 0, 1, 0,  0, 32'h0,        32'h10,   5'd0, 0, 0};
    // load 0x0 returns the second (wrapped) store
    vecs[8]  = '{32'h0,    32'h0,        5'd3, 1, 0, 1,  1, 32'h0,        32'h10,   5'd0, 0, 0};
    vecs[9]  = '{32'h0,    32'h0,        5'd3, 1, 0, 1,  1, 32'h0,        32'h10,   5'd0, 0, 0};
    vecs[10] = '{32'h0,    32'h0,        5'd3, 1, 0, 1,  0, 32'h22222222, 32'h0,    5'd3, 1, 1};
    // load 0x13 ignores the byte offset and returns word 4
    vecs[11] = '{32'h13,   32'h0,        5'd7, 1, 0, 1,  1, 32'h22222222, 32'h0,    5'd3, 0, 0};
    vecs[12] = '{32'h13,   32'h0,        5'd7, 1, 0, 1,  1, 32'h22222222, 32'h0,    5'd3, 0, 0};
    vecs[13] = '{32'h13,   32'h0,        5'd7, 1, 0, 1,  0, 32'h44444444, 32'h13,   5'd7, 1, 1};
    // MemWrite and MemToReg both set: store wins, no stall
    vecs[14] = '{32'h20,   32'hCAFEF00D, 5'd2, 0, 1, 1,  0, 32'h0,        32'h20,   5'd2, 0, 1};
    vecs[15] = '{32'h20,   32'h0,        5'd8, 1, 0, 1,  1, 32'h0,        32'h20,   5'd2, 0, 0};
    vecs[16] = '{32'h20,   32'h0,        5'd8, 1, 0, 1,  1, 32'h0,        32'h20,   5'd2, 0, 0};
    vecs[17] = '{32'h20,   32'h0,        5'd8, 1, 0, 1,  0, 32'hCAFEF00D, 32'h20,   5'd8, 1, 1};

    // Reset state
    rst_n = 1'b0;
    drive(32'h0, 32'h0, 5'd0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk_w("reset", 32'h0, 32'h0, 5'd0, 0, 0);
    chk("reset Stall", 32'(stall), 32'h0);
`ifdef MEMSTAGE_PERF_EN
    chk("reset StallCnt", 32'(stall_cnt), 32'h0);
`endif
    // A load presented under reset must not raise Stall
    drive(32'h10, 32'h0, 5'd1, 1, 0, 1);
    #1;
    chk("reset load Stall", 32'(stall), 32'h0);
    drive(32'h0, 32'h0, 5'd0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("idle Stall", 32'(stall), 32'h0);
    @(posedge clk);
    #1;
    chk_w("idle", 32'h0, 32'h0, 5'd0, 0, 0);

    // Table-driven cycles
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].alu, vecs[i].wd, vecs[i].wreg, vecs[i].rw, vecs[i].mw, vecs[i].m2r);
      @(negedge clk);
      chk($sformatf("v%0d Stall", i), 32'(stall), 32'(vecs[i].e_stall));
      @(posedge clk);
      #1;
      chk_w($sformatf("v%0d", i), vecs[i].e_rd, vecs[i].e_alu, vecs[i].e_wreg,
            vecs[i].e_rw, vecs[i].e_m2r);
    end

    // Reset pulse during the first WAIT cycle of a load
    drive(32'h20, 32'h0, 5'd4, 1, 0, 1);
    @(negedge clk);
    chk("rstwait c0 Stall", 32'(stall), 32'h1);
    @(posedge clk);
    #1;
    chk("rstwait c1 Stall", 32'(stall), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rstwait asserted Stall", 32'(stall), 32'h0);
    chk_w("rstwait asserted", 32'h0, 32'h0, 5'd0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("restart c0 Stall", 32'(stall), 32'h1);
    @(posedge clk);
    #1;
    chk("restart c1 Stall", 32'(stall), 32'h1);
    chk("restart c1 RegWriteW", 32'(rw_w), 32'h0);
    @(posedge clk);
    #1;
    chk("restart c2 Stall", 32'(stall), 32'h0);
    chk("restart c2 RegWriteW", 32'(rw_w), 32'h0);
    @(posedge clk);
    #1;
    chk_w("restart done", 32'hCAFEF00D, 32'h20, 5'd4, 1, 1);
    drive(32'h0, 32'h0, 5'd0, 0, 0, 0);

`ifdef MEMSTAGE_PERF_EN
    // Three back-to-back loads accumulate 6 stall cycles
    rst_n = 1'b0;
    #1;
    chk("perf reset StallCnt", 32'(stall_cnt), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(32'h20, 32'h0, 5'd1, 1, 0, 1);
    repeat (9) @(posedge clk);
    #1;
    drive(32'h0, 32'h0, 5'd0, 0, 0, 0);
    chk("perf 3 loads StallCnt", 32'(stall_cnt), 32'd6);
    // Saturation
    force dut.perf_cnt = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.perf_cnt;
    chk("perf preload StallCnt", 32'(stall_cnt), 32'hFFFF);
    drive(32'h20, 32'h0, 5'd1, 1, 0, 1);
    repeat (3) @(posedge clk);
    #1;
    drive(32'h0, 32'h0, 5'd0, 0, 0, 0);
    chk("perf saturated StallCnt", 32'(stall_cnt), 32'hFFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
